tick_pipe: RTL

//  Elastic multi-lane register pipeline generalising the single tock-reads-reg / tick-writes-reg pattern.
//  - Outputs are driven combinationally from the current stage registers (read-before-write), then stages update on the clock.
//  - DEPTH stages, each carrying CHANNELS lanes of WIDTH bits under one shared valid/ready handshake.
//  - Bubble-collapsing backpressure. Sits between producer and consumer blocks needing fixed-minimum latency plus stall tolerance.

---
 rtl/tick_pipe_pkg.sv | 10 +
 rtl/tick_pipe_stage.sv | 33 +++
 rtl/tick_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/tick_pipe_pkg.sv
// tick_pipe_pkg: default geometry for tick_pipe and the occupancy-width helper.
package tick_pipe_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/tick_pipe_stage.sv
// tick_pipe_stage: one pipeline slot, a valid bit plus all lanes of data under a shared handshake.
// Optional clear input when TICK_PIPE_FLUSH_EN is defined.
module tick_pipe_stage
    import tick_pipe_pkg::*;
#(
    parameter int DW = DEF_WIDTH * DEF_CHANNELS
) (
    input  logic          clock,
    input  logic          reset_n,
`ifdef TICK_PIPE_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          down_acc,
    output logic          valid,
    output logic [DW-1:0] data
);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (!valid || down_acc) begin
                valid <= up_valid;
                if (up_valid) data <= up_data;
            end
`ifdef TICK_PIPE_FLUSH_EN
            if (flush) valid <= 1'b0;
`endif
        end
    end
endmodule

// File: rtl/tick_pipe.sv
// tick_pipe: elastic DEPTH-stage, CHANNELS-lane register pipeline with bubble-collapsing backpressure.
// Defining TICK_PIPE_FLUSH_EN adds a flush port that empties the pipe at a clock edge.
module tick_pipe
    import tick_pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef TICK_PIPE_FLUSH_EN
    ,
    input  logic                      flush
`endif
);
    localparam int DW = CHANNELS * WIDTH;
    localparam int OW = occ_w(DEPTH);
    localparam logic [OW-1:0] ONE = OW'(1);

    logic [DEPTH:0]   w_acc;
    logic [DEPTH-1:0] w_v;
    logic [DW-1:0]    w_d [DEPTH];
    logic [OW-1:0]    r_occ;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_flush;

`ifdef TICK_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_acc[DEPTH] = out_ready;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            // Unrolled accept chain: a stage moves if any slot at or below it is empty, or the sink takes.
            assign w_acc[i] = out_ready | ~(&w_v[DEPTH-1:i]);
            if (i == 0) begin : g_head
                tick_pipe_stage #(.DW(DW)) u_stage (
                    .clock    (clock),
                    .reset_n  (reset_n),
`ifdef TICK_PIPE_FLUSH_EN
                    .flush    (w_flush),
`endif
                    .up_valid (in_valid),
                    .up_data  (in_data),
                    .down_acc (w_acc[1]),
                    .valid    (w_v[0]),
                    .data     (w_d[0])
                );
            end else begin : g_body
                tick_pipe_stage #(.DW(DW)) u_stage (
                    .clock    (clock),
                    .reset_n  (reset_n),
`ifdef TICK_PIPE_FLUSH_EN
                    .flush    (w_flush),
`endif
                    .up_valid (w_v[i-1]),
                    .up_data  (w_d[i-1]),
                    .down_acc (w_acc[i+1]),
                    .valid    (w_v[i]),
                    .data     (w_d[i])
                );
            end
        end
    endgenerate

    assign in_ready   = w_acc[0];
    assign out_valid  = w_v[DEPTH-1];
    assign out_data   = w_d[DEPTH-1];
    assign occupancy  = r_occ;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_occ <= '0;
        else if (w_flush) r_occ <= '0;
        else if (w_in_fire && !w_out_fire) r_occ <= r_occ + ONE;
        else if (!w_in_fire && w_out_fire) r_occ <= r_occ - ONE;
    end
endmodule
